// File: rtl/spi_word_tx_if.sv
// Handshake and SPI pin bundle for spi_word_tx.
// The master modport is the upstream word source; the slave modport is the transmitter itself.
interface spi_word_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             spi_sck;
    logic             pc_cs;
    logic             pc_mosi;

    modport master (
        output data_in, data_valid,
        input  data_ready, busy, spi_sck, pc_cs, pc_mosi
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, busy, spi_sck, pc_cs, pc_mosi
    );
endinterface

// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter: accepts one WIDTH-bit word on valid/ready and shifts it out MSB
// first. Every output is driven directly by a flop.
module spi_word_tx #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    spi_word_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next, shreg_shift;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [HW-1:0]    half_cnt_reg, half_cnt_next;
    logic             sck_reg, sck_next;
    logic             cs_reg, cs_next;
    logic             mosi_reg, mosi_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             half_done;

    assign half_done   = (half_cnt_reg == '0);
    assign shreg_shift = shreg_reg << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            sck_reg      <= 1'b0;
            cs_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            half_cnt_reg <= half_cnt_next;
            sck_reg      <= sck_next;
            cs_reg       <= cs_next;
            mosi_reg     <= mosi_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        half_cnt_next = half_cnt_reg;
        sck_next      = sck_reg;
        cs_next       = cs_reg;
        mosi_next     = mosi_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;

        case (state_reg)
            IDLE: begin
                if (bus.data_valid && ready_reg) begin
                    shreg_next    = bus.data_in;
                    mosi_next     = bus.data_in[WIDTH-1];
                    cs_next       = 1'b0;
                    ready_next    = 1'b0;
                    busy_next     = 1'b1;
                    sck_next      = 1'b0;
                    bit_cnt_next  = '0;
                    half_cnt_next = HALF_RELOAD;
                    state_next    = SHIFT;
                end
            end

            SHIFT: begin
                if (!half_done) begin
                    half_cnt_next = half_cnt_reg - 1'b1;
                end else begin
                    half_cnt_next = HALF_RELOAD;
                    if (!sck_reg) begin
                        sck_next     = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else begin
                        sck_next = 1'b0;
                        // After the last rise the final bit is left on mosi through HOLD.
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next = HOLD;
                        end else begin
                            shreg_next = shreg_shift;
                            mosi_next  = shreg_shift[WIDTH-1];
                        end
                    end
                end
            end

            HOLD: begin
                if (!half_done) begin
                    half_cnt_next = half_cnt_reg - 1'b1;
                end else begin
                    half_cnt_next = HALF_RELOAD;
                    cs_next       = 1'b1;
                    mosi_next     = 1'b0;
                    state_next    = GAP;
                end
            end

            GAP: begin
                if (!half_done) begin
                    half_cnt_next = half_cnt_reg - 1'b1;
                end else begin
                    half_cnt_next = '0;
                    bit_cnt_next  = '0;
                    ready_next    = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.data_ready = ready_reg;
    assign bus.busy       = busy_reg;
    assign bus.spi_sck    = sck_reg;
    assign bus.pc_cs      = cs_reg;
    assign bus.pc_mosi    = mosi_reg;
endmodule

// File: tb/tb_spi_word_tx.sv
// Scoreboard bench for spi_word_tx: a default 32-bit/div-2 instance plus an 8-bit/div-1 instance.
// Monitors decode frames from the pins; tasks compare them against words queued at drive time.
module tb_spi_word_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_word_tx_if #(.WIDTH(32)) bus ();
    spi_word_tx_if #(.WIDTH(8))  bus8 ();

    spi_word_tx #(.WIDTH(32), .CLK_DIV(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    spi_word_tx #(.WIDTH(8),  .CLK_DIV(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          rise_q[$];
    logic [7:0]  exp8_q[$];
    logic [7:0]  got8_q[$];
    int          rise8_q[$];
    int          stray = 0;
    int          stray8 = 0;

    // Pin monitors: sample at negedge, shift in mosi on every sck rise, close a frame on cs rise.
    logic [31:0] acc;
    int          rises;
    logic        sck_q, cs_q;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0; rises = 0; sck_q = 1'b0; cs_q = 1'b1;
        end else begin
            if (bus.spi_sck && !sck_q) begin
                if (bus.pc_cs) stray++;
                acc = {acc[30:0], bus.pc_mosi};
                rises++;
            end
            if (bus.pc_cs && !cs_q) begin
                got_q.push_back(acc); rise_q.push_back(rises);
                acc = '0; rises = 0;
            end
            sck_q = bus.spi_sck; cs_q = bus.pc_cs;
        end
    end

    logic [7:0] acc8;
    int         rises8;
    logic       sck8_q, cs8_q;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc8 = '0; rises8 = 0; sck8_q = 1'b0; cs8_q = 1'b1;
        end else begin
            if (bus8.spi_sck && !sck8_q) begin
                if (bus8.pc_cs) stray8++;
                acc8 = {acc8[6:0], bus8.pc_mosi};
                rises8++;
            end
            if (bus8.pc_cs && !cs8_q) begin
                got8_q.push_back(acc8); rise8_q.push_back(rises8);
                acc8 = '0; rises8 = 0;
            end
            sck8_q = bus8.spi_sck; cs8_q = bus8.pc_cs;
        end
    end

    task automatic test_reset();
        logic [4:0] exp_idle;
        exp_idle = 5'b0_1_0_1_0; // sck, cs, mosi, ready, busy
        rst_n = 1'b0;
        bus.data_in = 32'h6D73E55F; bus.data_valid = 1'b0;
        bus8.data_in = 8'h00;       bus8.data_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.data_valid = ~bus.data_valid;
            bus8.data_valid = ~bus8.data_valid;
            tests_run++;
            if ({bus.spi_sck, bus.pc_cs, bus.pc_mosi, bus.data_ready, bus.busy} !== exp_idle) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", i,
                         {bus.spi_sck, bus.pc_cs, bus.pc_mosi, bus.data_ready, bus.busy}, exp_idle);
            end
        end
        tests_run++;
        if ({bus8.spi_sck, bus8.pc_cs, bus8.pc_mosi, bus8.data_ready, bus8.busy} !== exp_idle) begin
            tests_failed++;
            $display("FAIL reset_outputs_w8: got %b expected %b",
                     {bus8.spi_sck, bus8.pc_cs, bus8.pc_mosi, bus8.data_ready, bus8.busy}, exp_idle);
        end
        bus.data_valid = 1'b0; bus8.data_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic check_frame(input string tag);
        logic [31:0] e, g;
        int r;
        tests_run++;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_frame: got %0d frames expected %0d", tag, got_q.size(), exp_q.size());
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front(); r = rise_q.pop_front();
            if (g !== e || r != 32) begin
                tests_failed++;
                $display("FAIL %s_frame: got %h/%0d rises expected %h/32 rises", tag, g, r, e);
            end else
                $display("[TB] %s frame %h decoded, %0d rises", tag, g, r);
        end
    endtask

    // One frame on the 32-bit instance; optionally pulses valid with all-ones at cycle poke_at.
    task automatic run_frame(input logic [31:0] word, input string tag, input int poke_at);
        int cs_rise, rdy;
        @(negedge clk);
        bus.data_in = word; bus.data_valid = 1'b1;
        exp_q.push_back(word);
        @(negedge clk);
        bus.data_valid = 1'b0;
        tests_run++;
        if ({bus.data_ready, bus.busy, bus.pc_cs, bus.pc_mosi} !== {1'b0, 1'b1, 1'b0, word[31]}) begin
            tests_failed++;
            $display("FAIL %s_accept: got rdy/busy/cs/mosi %b expected %b", tag,
                     {bus.data_ready, bus.busy, bus.pc_cs, bus.pc_mosi}, {1'b0, 1'b1, 1'b0, word[31]});
        end
        cs_rise = -1; rdy = -1;
        for (int n = 1; n <= 400 && rdy < 0; n++) begin
            @(negedge clk);
            if (n == poke_at) begin bus.data_in = 32'hFFFFFFFF; bus.data_valid = 1'b1; end
            if (n == poke_at + 1) begin bus.data_in = word; bus.data_valid = 1'b0; end
            if (bus.pc_cs && cs_rise < 0) cs_rise = n;
            if (bus.data_ready) rdy = n;
        end
        bus.data_valid = 1'b0;
        tests_run++;
        if (cs_rise != 130 || rdy != 132) begin
            tests_failed++;
            $display("FAIL %s_timing: cs rise E0+%0d ready E0+%0d expected E0+130 / E0+132", tag, cs_rise, rdy);
        end
        @(negedge clk);
        check_frame(tag);
    endtask

    task automatic test_single();
        run_frame(32'h6D73E55F, "single", -1);
    endtask

    task automatic test_ignore_busy();
        run_frame(32'hA0C3_5F12, "ignore", 40);
        repeat (20) @(negedge clk);
        tests_run++;
        if (got_q.size() != 0 || !bus.pc_cs || !bus.data_ready) begin
            tests_failed++;
            $display("FAIL ignore_no_second_frame: extra frames %0d cs %b ready %b expected 0/1/1",
                     got_q.size(), bus.pc_cs, bus.data_ready);
        end
    endtask

    task automatic test_back_to_back();
        int rdy, cs_high;
        @(negedge clk);
        bus.data_in = 32'hB11AF0E1; bus.data_valid = 1'b1;
        exp_q.push_back(32'hB11AF0E1);
        exp_q.push_back(32'h00000001);
        @(negedge clk);
        bus.data_in = 32'h00000001;
        rdy = -1; cs_high = 0;
        for (int n = 1; n <= 400 && rdy < 0; n++) begin
            @(negedge clk);
            if (bus.pc_cs) cs_high++;
            if (bus.data_ready) rdy = n;
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
        tests_run++;
        if (rdy != 132 || bus.data_ready !== 1'b0 || bus.pc_cs !== 1'b0 || cs_high != 3) begin
            tests_failed++;
            $display("FAIL b2b_gap: ready E0+%0d, re-accept rdy %b cs %b, cs high %0d cycles expected 132/0/0/3",
                     rdy, bus.data_ready, bus.pc_cs, cs_high);
        end
        rdy = -1;
        for (int n = 1; n <= 400 && rdy < 0; n++) begin
            @(negedge clk);
            if (bus.data_ready) rdy = n;
        end
        tests_run++;
        if (rdy != 132) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: ready E0+%0d expected E0+132", rdy);
        end
        @(negedge clk);
        check_frame("b2b_first");
        check_frame("b2b_second");
        tests_run++;
        if (got_q.size() != 0 || stray != 0) begin
            tests_failed++;
            $display("FAIL b2b_extra: extra frames %0d stray sck rises %0d expected 0/0", got_q.size(), stray);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        bus.data_in = 32'hCAFEF00D; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.spi_sck, bus.pc_cs, bus.pc_mosi, bus.data_ready, bus.busy} !== 5'b01010) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %b expected 01010",
                     {bus.spi_sck, bus.pc_cs, bus.pc_mosi, bus.data_ready, bus.busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_q.size() != 0 || bus.pc_cs !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_resume: frames %0d cs %b busy %b expected 0/1/0",
                     got_q.size(), bus.pc_cs, bus.busy);
        end
        run_frame(32'h12345678, "after_reset", -1);
    endtask

    task automatic test_width8_div1();
        int cs_rise, rdy;
        logic [7:0] g;
        int r;
        @(negedge clk);
        bus8.data_in = 8'hA5; bus8.data_valid = 1'b1;
        exp8_q.push_back(8'hA5);
        @(negedge clk);
        bus8.data_valid = 1'b0;
        cs_rise = -1; rdy = -1;
        for (int n = 1; n <= 100 && rdy < 0; n++) begin
            @(negedge clk);
            if (bus8.pc_cs && cs_rise < 0) cs_rise = n;
            if (bus8.data_ready) rdy = n;
        end
        tests_run++;
        if (cs_rise != 17 || rdy != 18) begin
            tests_failed++;
            $display("FAIL w8_timing: cs rise E0+%0d ready E0+%0d expected E0+17 / E0+18", cs_rise, rdy);
        end
        @(negedge clk);
        tests_run++;
        if (got8_q.size() != 1 || exp8_q.size() != 1) begin
            tests_failed++;
            $display("FAIL w8_frame: got %0d frames expected 1", got8_q.size());
        end else begin
            g = got8_q.pop_front(); r = rise8_q.pop_front();
            if (g !== exp8_q[0] || r != 8 || stray8 != 0) begin
                tests_failed++;
                $display("FAIL w8_frame: got %h/%0d rises/%0d stray expected %h/8/0", g, r, stray8, exp8_q[0]);
            end else
                $display("[TB] w8 frame %h decoded, %0d rises", g, r);
            void'(exp8_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_width8_div1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
